// File: rtl/pack_leb128_if.sv
// pack_leb128_if: operand-in / byte-out handshake bundle for the LEB128 encoder
//   in_*  : one integer per transaction (valid/ready)
//   out_* : encoded byte stream, out_last marks the final byte, out_len its count
interface pack_leb128_if #(parameter int DW = 64);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_value;
  logic          in_signed;
  logic          in_is32;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic          out_last;
  logic [3:0]    out_len;
  modport slave (
    input  in_valid, in_value, in_signed, in_is32, out_ready,
    output in_ready, out_valid, out_byte, out_last, out_len
  );
  modport master (
    output in_valid, in_value, in_signed, in_is32, out_ready,
    input  in_ready, out_valid, out_byte, out_last, out_len
  );
endinterface

// File: rtl/pack_leb128.sv
// pack_leb128: sequential wasm LEB128 encoder (varuintN / varintN), one byte per cycle
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : pack_leb128_if.slave (operand handshake in, byte stream out)
module pack_leb128 #(
  parameter int DW     = 64,
  parameter int MAXLEN = 10
) (
  input logic            clk,
  input logic            reset,
  pack_leb128_if.slave   bus
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t      state, state_nx;
  logic [63:0] v, v_nx, v_in, rest;
  logic [3:0]  cnt, cnt_nx;
  logic        sgn, sgn_nx, is32, is32_nx, is32_in, last, emit;
  // a 32-bit build has no i64 mode, so every operand is an i32
  assign is32_in = (DW == 32) || bus.in_is32;
  assign v_in = !is32_in ? 64'(bus.in_value) :
                bus.in_signed ? {{32{bus.in_value[31]}}, bus.in_value[31:0]} :
                                {32'b0, bus.in_value[31:0]};
  assign rest = sgn ? $unsigned($signed(v) >>> 7) : v >> 7;
  // signed streams stop once the remaining bits are pure sign fill of bit 6;
  // the length cap bounds the byte count regardless of what is left in v
  assign last = (cnt == (is32 ? 4'd5 : 4'(MAXLEN))) ||
                (sgn ? ((rest == '0 && !v[6]) || (rest == '1 && v[6])) : rest == '0);
  assign emit          = state == EMIT;
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = emit;
  assign bus.out_byte  = emit ? {~last, v[6:0]} : 8'h00;
  assign bus.out_last  = emit && last;
  assign bus.out_len   = (emit && last) ? cnt : 4'd0;
  always_comb begin
    state_nx = state;
    v_nx     = v;
    cnt_nx   = cnt;
    sgn_nx   = sgn;
    is32_nx  = is32;
    if (state == IDLE) begin
      if (bus.in_valid) begin
        v_nx     = v_in;
        cnt_nx   = 4'd1;
        sgn_nx   = bus.in_signed;
        is32_nx  = is32_in;
        state_nx = EMIT;
      end
    end else if (bus.out_ready) begin
      v_nx     = rest;
      cnt_nx   = cnt + 4'd1;
      state_nx = last ? IDLE : EMIT;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      v     <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      is32  <= 1'b0;
    end else begin
      state <= state_nx;
      v     <= v_nx;
      cnt   <= cnt_nx;
      sgn   <= sgn_nx;
      is32  <= is32_nx;
    end
  end
endmodule

// File: tb/tb_pack_leb128.sv
// tb_pack_leb128: scoreboard bench for pack_leb128 with directed LEB128 vectors
module tb_pack_leb128;
  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [3:0] len;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passes = 0;
  int popped = 0;
  exp_t q [$];
  pack_leb128_if #(.DW(64)) bus ();
  pack_leb128 #(.DW(64), .MAXLEN(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask
  // bytes listed first-byte-first in the most significant end of bs
  task automatic expect_stream(input logic [79:0] bs, input int n);
    for (int i = 0; i < n; i++)
      q.push_back('{b: bs[8*(n-1-i) +: 8], last: (i == n - 1), len: 4'(n)});
  endtask
  task automatic send(input logic [63:0] val, input logic sg, input logic i32);
    int g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      checks++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.in_value  = val;
    bus.in_signed = sg;
    bus.in_is32   = i32;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || !bus.in_ready) && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.out_byte);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_byte", 64'(bus.out_byte), 64'(e.b));
        chk("out_last", 64'(bus.out_last), 64'(e.last));
        if (e.last) chk("out_len", 64'(bus.out_len), 64'(e.len));
        popped++;
      end
    end
  end
  initial begin
    int g;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_signed = 1'b0;
    bus.in_is32   = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_byte", 64'(bus.out_byte), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_len", 64'(bus.out_len), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    expect_stream({8'hE5, 8'h8E, 8'h26}, 3);
    send(64'd624485, 1'b0, 1'b1);
    drain();
    expect_stream({8'hC0, 8'hBB, 8'h78}, 3);
    send(-64'sd123456, 1'b1, 1'b1);
    expect_stream(80'h7F, 1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    expect_stream(80'h00, 1);
    send(64'd0, 1'b1, 1'b0);
    expect_stream(80'h00, 1);
    send(64'd0, 1'b0, 1'b0);
    expect_stream({8'h3F}, 1);
    send(64'd63, 1'b1, 1'b0);
    expect_stream({8'hC0, 8'h00}, 2);
    send(64'd64, 1'b1, 1'b0);
    expect_stream({8'h80, 8'h01}, 2);
    send(64'd128, 1'b0, 1'b0);
    expect_stream({{9{8'hFF}}, 8'h01}, 10);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    expect_stream({{9{8'h80}}, 8'h7F}, 10);
    send(64'h8000_0000_0000_0000, 1'b1, 1'b0);
    expect_stream({8'h80, 8'h80, 8'h80, 8'h80, 8'h78}, 5);
    send(64'h1234_5678_8000_0000, 1'b1, 1'b1);
    expect_stream({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F}, 5);
    send(64'hDEAD_BEEF_FFFF_FFFF, 1'b0, 1'b1);
    drain();
    // backpressure on the second byte of 624485
    expect_stream({8'hE5, 8'h8E, 8'h26}, 3);
    send(64'd624485, 1'b0, 1'b1);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_byte", 64'(bus.out_byte), 64'h8E);
      chk("bp_last", 64'(bus.out_last), 64'd0);
    end
    bus.out_ready = 1'b1;
    drain();
    // reset in the middle of a 10-byte stream
    g = popped;
    expect_stream({{9{8'hFF}}, 8'h01}, 10);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    for (int i = 0; i < 100 && popped < g + 4; i++) @(posedge clk);
    chk("mid_popped", 64'(popped - g), 64'd4);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_byte", 64'(bus.out_byte), 64'd0);
    chk("mid_rst_len", 64'(bus.out_len), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    expect_stream(80'h05, 1);
    send(64'd5, 1'b0, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
